stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Front-end controller for the stopwatch counter datapath.
- Debounces the start, stop and lap buttons and turns each into a single-cycle event.
- Runs an IDLE/RUNNING/PAUSED/LAP_HOLD sequencer that drives the counter's enable, clear, lap-capture and display-hold controls.
- Owns the tick prescaler, so the counter advances once per TICK_DIV clocks, and pausing keeps the partial tick.

Parameters:
- DEBOUNCE, 3: consecutive stable synchronized samples required to accept a button level change (min 1).
- TICK_DIV, 4: clocks per counter increment while counting (min 1; 1 means enable every cycle).

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  synchronous, active-low reset, sampled on rising edge of i_clk.
- i_start  in  1  raw start button, asynchronous, active high.
- i_stop  in  1  raw stop button, asynchronous, active high.
- i_lap  in  1  raw lap button, asynchronous, active high.
- o_count_en  out  1  counter increment strobe.
- o_count_clr  out  1  counter clear strobe, one cycle.
- o_lap_load  out  1  lap register capture strobe, one cycle.
- o_display_hold  out  1  freeze displayed value; counter keeps running.
- o_state  out  2  0=IDLE, 1=RUNNING, 2=PAUSED, 3=LAP_HOLD.

Behaviour:
- Reset (i_reset_n=0 at an edge):
  - state=IDLE; all outputs 0.
  - Sync flops, debounced levels, stability counters, edge flops and prescaler all cleared.
- Button pipeline, identical for each of the three buttons:
  - 2-FF synchronizer.
  - Stability counter increments while the synchronized level differs from the debounced level; it clears to 0 when they match.
  - The debounced level takes the synchronized value on the edge where the counter would reach DEBOUNCE; the counter clears on that edge.
  - Registered event pulse = debounced rising edge. Falling edges produce no event.
  - Any glitch shorter than DEBOUNCE synchronized cycles produces no event.
- Latency: button first sampled high at edge E0 and held steady -> event register high after edge E(DEBOUNCE+2) -> o_state and strobes update at edge E(DEBOUNCE+3).
- A button held through reset release produces one event after the same latency.
- Simultaneous events: priority stop > start > lap. Only the winning event acts; lower-priority events in that cycle are discarded, not queued.
- FSM transitions (events not listed are ignored):
  - IDLE + start -> RUNNING; prescaler cleared.
  - IDLE + stop -> IDLE; o_count_clr pulses.
  - RUNNING + stop -> PAUSED.
  - RUNNING + lap -> LAP_HOLD; o_lap_load pulses.
  - LAP_HOLD + lap -> LAP_HOLD; o_lap_load pulses again.
  - LAP_HOLD + start -> RUNNING.
  - LAP_HOLD + stop -> PAUSED.
  - PAUSED + start -> RUNNING; prescaler not cleared.
  - PAUSED + stop -> IDLE; o_count_clr pulses.
- Strobe timing: o_count_clr and o_lap_load are registered and high for exactly the one cycle after the transition edge, i.e. in the same cycle o_state first shows the new state.
- o_display_hold = 1 iff state==LAP_HOLD (registered with state).
- Prescaler:
  - Width clog2(TICK_DIV) (min 1 bit).
  - Counts only in RUNNING or LAP_HOLD; holds its value in PAUSED and IDLE.
  - Wraps TICK_DIV-1 -> 0.
  - o_count_en is high for one cycle on each wrap.
  - First o_count_en comes TICK_DIV cycles after entering RUNNING from IDLE.
  - o_count_en is never high in IDLE or PAUSED.
- Mid-operation reset returns to IDLE on that edge and kills any in-flight debounce or event. o_count_clr is not pulsed; the datapath has its own reset.

Test Plan:
- Reset, then DEBOUNCE=3, TICK_DIV=4, i_start high for 10 cycles -> o_state=1 exactly 6 edges after first sampled-high edge; o_count_en pulses every 4th cycle, first 4 cycles after entry.
- i_start pulses of 1 and 2 cycles (glitches) -> no event, o_state stays 0, no strobes.
- RUNNING, i_lap press -> o_state=3, o_lap_load=1 for 1 cycle, o_display_hold=1, o_count_en keeps 1-in-4 cadence; second lap -> second o_lap_load pulse; start -> o_state=1, hold=0.
- RUNNING, stop after 6 prescaler counts -> PAUSED with no o_count_en; start -> first o_count_en 2 cycles after re-entry; stop, stop -> IDLE with one o_count_clr pulse.
- Start and stop pressed in the same cycle from IDLE -> stop wins: o_count_clr pulse, o_state stays 0; from RUNNING -> PAUSED.
- i_reset_n=0 for 1 cycle while RUNNING with lap debounce in progress -> all outputs 0, o_state=0, no later lap event; i_start held across reset -> RUNNING 6 edges after release.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: debounces start/stop/lap buttons into single-cycle events,
// sequences IDLE/RUNNING/PAUSED/LAP_HOLD and owns the count-enable prescaler.
module stopwatch_ctrl #(
  parameter int DEBOUNCE = 3,
  parameter int TICK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_lap,
  output logic       o_count_en,
  output logic       o_count_clr,
  output logic       o_lap_load,
  output logic       o_display_hold,
  output logic [1:0] o_state
);

  // The stability counter clears on acceptance, so it never has to hold DEBOUNCE itself.
  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_PAUSED   = 2'd2,
    ST_LAP_HOLD = 2'd3
  } state_t;

  // Button index: 0 = start, 1 = stop, 2 = lap.
  logic [2:0]            btn_raw_s;
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            deb_q, deb_d, deb_prev_q;
  logic [2:0]            evt_q;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             count_en_q, count_clr_q, lap_load_q, display_hold_q;
  logic             clr_d, load_d, presc_clr_s;
  logic             ev_stop_s, ev_start_s, ev_lap_s;
  logic             counting_s, wrap_s;

  assign btn_raw_s = {i_lap, i_stop, i_start};

  // Debounce next-state: accept a new level only after DEBOUNCE consecutive differing samples.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int b = 0; b < 3; b++) begin
      if (sync2_q[b] == deb_q[b]) begin
        cnt_d[b] = {CNT_W{1'b0}};
      end else if (cnt_q[b] == CNT_LAST) begin
        deb_d[b] = sync2_q[b];
        cnt_d[b] = {CNT_W{1'b0}};
      end else begin
        cnt_d[b] = cnt_q[b] + CNT_W'(1);
      end
    end
  end

  // Synchronizers, debounced levels and registered rising-edge events.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync1_q    <= 3'b000;
      sync2_q    <= 3'b000;
      deb_q      <= 3'b000;
      deb_prev_q <= 3'b000;
      evt_q      <= 3'b000;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= btn_raw_s;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      evt_q      <= deb_q & ~deb_prev_q;
      cnt_q      <= cnt_d;
    end
  end

  // Only the highest-priority event acts; the others are dropped.
  assign ev_stop_s  = evt_q[1];
  assign ev_start_s = evt_q[0] & ~evt_q[1];
  assign ev_lap_s   = evt_q[2] & ~evt_q[0] & ~evt_q[1];

  // Sequencer next-state and strobe decode.
  always_comb begin
    state_d     = state_q;
    clr_d       = 1'b0;
    load_d      = 1'b0;
    presc_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ev_stop_s) begin
          clr_d = 1'b1;
        end else if (ev_start_s) begin
          state_d     = ST_RUNNING;
          presc_clr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUNNING: begin
        if (ev_stop_s) begin
          state_d = ST_PAUSED;
        end else if (ev_lap_s) begin
          state_d = ST_LAP_HOLD;
          load_d  = 1'b1;
        end else begin
          state_d = ST_RUNNING;
        end
      end
      ST_PAUSED: begin
        if (ev_stop_s) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end else if (ev_start_s) begin
          state_d = ST_RUNNING;
        end else begin
          state_d = ST_PAUSED;
        end
      end
      ST_LAP_HOLD: begin
        if (ev_stop_s) begin
          state_d = ST_PAUSED;
        end else if (ev_start_s) begin
          state_d = ST_RUNNING;
        end else if (ev_lap_s) begin
          load_d = 1'b1;
        end else begin
          state_d = ST_LAP_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Prescaler advances only while counting before and after the edge, so a pause keeps the partial tick.
  assign counting_s = ((state_q == ST_RUNNING) || (state_q == ST_LAP_HOLD)) &&
                      ((state_d == ST_RUNNING) || (state_d == ST_LAP_HOLD));
  assign wrap_s     = counting_s && (presc_q == PRE_LAST);

  // Prescaler next value.
  always_comb begin
    presc_d = presc_q;
    if (presc_clr_s) begin
      presc_d = {PRE_W{1'b0}};
    end else if (wrap_s) begin
      presc_d = {PRE_W{1'b0}};
    end else if (counting_s) begin
      presc_d = presc_q + PRE_W'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  // Sequencer state, prescaler and registered control outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q        <= ST_IDLE;
      presc_q        <= {PRE_W{1'b0}};
      count_en_q     <= 1'b0;
      count_clr_q    <= 1'b0;
      lap_load_q     <= 1'b0;
      display_hold_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      count_en_q     <= wrap_s;
      count_clr_q    <= clr_d;
      lap_load_q     <= load_d;
      display_hold_q <= (state_d == ST_LAP_HOLD);
    end
  end

  assign o_count_en     = count_en_q;
  assign o_count_clr    = count_clr_q;
  assign o_lap_load     = lap_load_q;
  assign o_display_hold = display_hold_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a cycle model pushes expected outputs per edge,
// which are popped and compared half a cycle later, plus directed timing checks.
module tb_stopwatch_ctrl;
  localparam int DB = 3;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, lap;
  logic       en, clr, load, hold;
  logic [1:0] st;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEBOUNCE(DB), .TICK_DIV(TD)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_stop(stop), .i_lap(lap),
    .o_count_en(en), .o_count_clr(clr), .o_lap_load(load), .o_display_hold(hold),
    .o_state(st)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int chg_cyc = 0;
  int clr_n = 0;
  int load_n = 0;
  logic [1:0] prev_st = 2'd0;
  int en_hist[$];
  logic [5:0] exp_q[$];

  // Reference model state (button index 0 = start, 1 = stop, 2 = lap)
  logic [2:0]    m_s1, m_s2, m_deb, m_prev, m_ev;
  logic [DB-1:0] m_win [3];
  logic [1:0]    m_st;
  int            m_presc;
  logic          m_en, m_clr, m_load;

  task automatic model_edge(input logic r, input logic [2:0] raw);
    logic [2:0]    ev_old;
    logic [1:0]    st_old;
    logic [DB-1:0] w;
    logic          ws, wst, wl, cnt_ok;
    if (!r) begin
      m_s1 = 3'b0; m_s2 = 3'b0; m_deb = 3'b0; m_prev = 3'b0; m_ev = 3'b0;
      for (int b = 0; b < 3; b++) m_win[b] = '0;
      m_st = 2'd0; m_presc = 0; m_en = 1'b0; m_clr = 1'b0; m_load = 1'b0;
    end else begin
      ev_old = m_ev;
      st_old = m_st;
      for (int b = 0; b < 3; b++) begin
        // level accepted once the last DB synchronized samples all disagree with it
        w = (m_win[b] << 1) | DB'(m_s2[b]);
        m_win[b] = w;
        m_ev[b] = m_deb[b] & ~m_prev[b];
        m_prev[b] = m_deb[b];
        if (w == {DB{~m_deb[b]}}) m_deb[b] = ~m_deb[b];
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
      ws  = ev_old[1];
      wst = ev_old[0] & ~ev_old[1];
      wl  = ev_old[2] & ~ev_old[0] & ~ev_old[1];
      m_clr = 1'b0;
      m_load = 1'b0;
      case (st_old)
        2'd0: if (ws) m_clr = 1'b1; else if (wst) begin m_st = 2'd1; m_presc = 0; end
        2'd1: if (ws) m_st = 2'd2; else if (wl) begin m_st = 2'd3; m_load = 1'b1; end
        2'd2: if (ws) begin m_st = 2'd0; m_clr = 1'b1; end else if (wst) m_st = 2'd1;
        2'd3: if (ws) m_st = 2'd2; else if (wst) m_st = 2'd1; else if (wl) m_load = 1'b1;
        default: m_st = 2'd0;
      endcase
      cnt_ok = (st_old == 2'd1 || st_old == 2'd3) && (m_st == 2'd1 || m_st == 2'd3);
      m_en = 1'b0;
      if (cnt_ok) begin
        if (m_presc == TD - 1) begin m_en = 1'b1; m_presc = 0; end
        else m_presc = m_presc + 1;
      end
    end
    exp_q.push_back({m_st, m_en, m_clr, m_load, (m_st == 2'd3)});
  endtask

  task automatic check_val(input string tag, input int got, input int exp_v);
    total++;
    assert (got === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp_v);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic p, input logic l);
    logic [5:0] e;
    rst_n = r; start = s; stop = p; lap = l;
    @(posedge clk);
    cyc++;
    model_edge(r, {l, p, s});
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    assert ({st, en, clr, load, hold} === e) else begin
      bad++;
      $error("FAIL cycle %0d outputs {st,en,clr,load,hold}: got %b expected %b",
             cyc, {st, en, clr, load, hold}, e);
    end
    if (en === 1'b1) en_hist.push_back(cyc);
    if (clr === 1'b1) clr_n++;
    if (load === 1'b1) load_n++;
    if (st !== prev_st) chg_cyc = cyc;
    prev_st = st;
  endtask

  task automatic press(input logic [2:0] m, input int hold_n, input int idle_n);
    for (int i = 0; i < hold_n; i++) step(1'b1, m[0], m[1], m[2]);
    for (int i = 0; i < idle_n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int first, c0, entry, gaps_bad, pause_cyc, last_en, presc_at_pause, resume;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; lap = 1'b0;

    // reset
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("reset_outputs", int'({st, en, clr, load, hold}), 0);

    // glitches of 1 and 2 cycles
    clr_n = 0; load_n = 0; en_hist.delete();
    press(3'b001, 1, 8);
    press(3'b001, 2, 8);
    check_val("glitch_state", int'(st), 0);
    check_val("glitch_strobes", clr_n + load_n + en_hist.size(), 0);

    // start held 10 cycles
    en_hist.delete(); first = -1; c0 = cyc;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (st === 2'd1 && first < 0) first = i;
    end
    check_val("start_latency", first - 1, DB + 3);
    entry = c0 + first;
    press(3'b000, 0, 8);
    check_val("en_count_after_start", int'(en_hist.size() >= 2), 1);
    if (en_hist.size() >= 2) begin
      check_val("first_en", en_hist[0] - entry, TD);
      check_val("en_gap", en_hist[1] - en_hist[0], TD);
    end

    // lap, lap again, start back to running
    en_hist.delete(); load_n = 0;
    press(3'b100, 4, 8);
    check_val("lap_state", int'(st), 3);
    check_val("lap_hold", int'(hold), 1);
    check_val("lap_load_1", load_n, 1);
    press(3'b100, 4, 8);
    check_val("lap_load_2", load_n, 2);
    press(3'b001, 4, 8);
    check_val("lap_resume_state", int'(st), 1);
    check_val("lap_resume_hold", int'(hold), 0);
    check_val("lap_en_count", en_hist.size(), 36 / TD);
    gaps_bad = 0;
    for (int i = 1; i < en_hist.size(); i++) if (en_hist[i] - en_hist[i-1] != TD) gaps_bad++;
    check_val("lap_cadence", gaps_bad, 0);

    // pause keeps partial tick
    en_hist.delete();
    press(3'b010, 4, 10);
    pause_cyc = chg_cyc;
    check_val("pause_state", int'(st), 2);
    last_en = -1;
    for (int i = 0; i < en_hist.size(); i++) if (en_hist[i] < pause_cyc) last_en = en_hist[i];
    check_val("pause_no_en", int'(en_hist.size() > 0 && en_hist[$] >= pause_cyc), 0);
    presc_at_pause = (last_en < 0) ? 0 : (pause_cyc - 1 - last_en) % TD;
    en_hist.delete();
    press(3'b001, 4, 8);
    resume = chg_cyc;
    check_val("resume_state", int'(st), 1);
    check_val("resume_en_seen", int'(en_hist.size() > 0), 1);
    if (en_hist.size() > 0) check_val("resume_gap", en_hist[0] - resume, TD - presc_at_pause);

    // stop, stop -> idle with one clear
    clr_n = 0;
    press(3'b010, 4, 8);
    press(3'b010, 4, 8);
    check_val("stop_stop_state", int'(st), 0);
    check_val("stop_stop_clr", clr_n, 1);

    // simultaneous start+stop from IDLE, then from RUNNING
    clr_n = 0;
    press(3'b011, 4, 8);
    check_val("simul_idle_state", int'(st), 0);
    check_val("simul_idle_clr", clr_n, 1);
    press(3'b001, 4, 8);
    press(3'b011, 4, 8);
    check_val("simul_run_state", int'(st), 2);
    press(3'b010, 4, 8);

    // reset mid-run with lap debounce in flight
    press(3'b001, 4, 8);
    load_n = 0;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("rst_mid_outputs", int'({st, en, clr, load, hold}), 0);
    press(3'b000, 0, 10);
    check_val("rst_mid_state", int'(st), 0);
    check_val("rst_mid_no_lap", load_n, 0);

    // start held across reset
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (st === 2'd1 && first < 0) first = i;
    end
    check_val("held_start_latency", first - 1, DB + 3);
    press(3'b000, 0, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
